// File: rtl/risc_pkg.sv
// Shared widths, reset constants and control bundles for the EX/MEM stage.
package risc_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned RD_W     = 3;
  localparam int unsigned SP_RESET = 2047;

  typedef struct packed {
    logic read;
    logic write;
    logic push;
    logic pop;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with push/pop address formation.
// Optional under/overflow guard enabled by macro STACK_GUARD_EN.
module stack_pointer_unit
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              push_req,
  input  logic              pop_req,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] stack_addr,
  output logic              push_ok,
  output logic              pop_ok,
  output logic              guard_fault
);

  localparam logic [ADDR_W-1:0] SpInit = ADDR_W'(SP_RESET);

  logic [ADDR_W-1:0] sp_q, sp_d;

  always_comb begin
    push_ok     = push_req;
    pop_ok      = pop_req;
    guard_fault = 1'b0;
`ifdef STACK_GUARD_EN
    if (push_req && (sp_q == '0)) begin
      push_ok     = 1'b0;
      guard_fault = 1'b1;
    end
    if (pop_req && (sp_q == SpInit)) begin
      pop_ok      = 1'b0;
      guard_fault = 1'b1;
    end
`endif
    // Push uses SP as-is (post-decrement), pop uses SP+1 (pre-increment).
    stack_addr = pop_req ? sp_q + ADDR_W'(1) : sp_q;

    sp_d = sp_q;
    if (!stall && !flush) begin
      if (push_ok) begin
        sp_d = sp_q - ADDR_W'(1);
      end else if (pop_ok) begin
        sp_d = sp_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= SpInit;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign sp = sp_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: owns the stack pointer, forms memory addresses, forwards WB controls.
// Macro STACK_GUARD_EN turns stack under/overflow into bubbles plus a sticky fault.
module ex_mem_stage
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_push,
  input  logic              ex_pop,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              memory_read,
  output logic              memory_write,
  output logic              memory_push,
  output logic              memory_pop,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [RD_W-1:0]   mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic [ADDR_W-1:0] sp_out,
  output logic              stack_fault
);

  mem_ctrl_t         mem_ctrl_q, mem_ctrl_d;
  wb_ctrl_t          wb_ctrl_q, wb_ctrl_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              fault_q, fault_d;

  logic [2:0]        op_count;
  logic              illegal;
  logic              push_ok, pop_ok, guard_fault;
  logic [ADDR_W-1:0] stack_addr;

  assign op_count = {2'b00, ex_mem_read} + {2'b00, ex_mem_write} +
                    {2'b00, ex_push} + {2'b00, ex_pop};
  assign illegal  = (op_count > 3'd1);

  stack_pointer_unit u_sp (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .push_req    (ex_push & ~illegal),
    .pop_req     (ex_pop & ~illegal),
    .sp          (sp_out),
    .stack_addr  (stack_addr),
    .push_ok     (push_ok),
    .pop_ok      (pop_ok),
    .guard_fault (guard_fault)
  );

  always_comb begin
    mem_ctrl_d   = mem_ctrl_q;
    wb_ctrl_d    = wb_ctrl_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    alu_d        = alu_q;
    rd_d         = rd_q;
    fault_d      = fault_q;
    if (flush) begin
      // Bubble: controls cleared, data fields keep their last values.
      mem_ctrl_d = '0;
      wb_ctrl_d  = '0;
    end else if (!stall) begin
      write_data_d = ex_store_data;
      alu_d        = ex_alu_result;
      rd_d         = ex_rd;
      address_d    = ex_alu_result[ADDR_W-1:0];
      mem_ctrl_d   = '{read: ex_mem_read, write: ex_mem_write, push: push_ok, pop: pop_ok};
      wb_ctrl_d    = '{reg_write: ex_reg_write, mem_to_reg: ex_mem_to_reg};
      if (push_ok || pop_ok) begin
        address_d = stack_addr;
      end
      if (illegal || guard_fault) begin
        mem_ctrl_d = '0;
        wb_ctrl_d  = '0;
        fault_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl_q   <= '0;
      wb_ctrl_q    <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      alu_q        <= '0;
      rd_q         <= '0;
      fault_q      <= 1'b0;
    end else begin
      mem_ctrl_q   <= mem_ctrl_d;
      wb_ctrl_q    <= wb_ctrl_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      alu_q        <= alu_d;
      rd_q         <= rd_d;
      fault_q      <= fault_d;
    end
  end

  assign memory_read    = mem_ctrl_q.read;
  assign memory_write   = mem_ctrl_q.write;
  assign memory_push    = mem_ctrl_q.push;
  assign memory_pop     = mem_ctrl_q.pop;
  assign address        = address_q;
  assign write_data     = write_data_q;
  assign mem_alu_result = alu_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = wb_ctrl_q.reg_write;
  assign mem_mem_to_reg = wb_ctrl_q.mem_to_reg;
  assign stack_fault    = fault_q;

endmodule
